// File: rtl/fp_mult_param.sv
// Sequential shift-add floating-point multiplier with selectable rounding,
// special-value handling and overflow/underflow/invalid flags.
module fp_mult_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [EXP_W+MAN_W:0]     inBus,
  input  logic                     startFP,
  input  logic                     rndMode,
  output logic [EXP_W+MAN_W:0]     resBus,
  output logic                     doneFP,
  output logic                     busy,
  output logic                     ovf,
  output logic                     unf,
  output logic                     inv
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int P  = MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(P + 1);
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EONE = EW'(1);
  localparam logic [W-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, CHECK, MULT, NORM, ROUND
  } state_t;

  state_t state, nextState;

  logic [W-1:0]     aReg, bReg;
  logic             rnd, sgn;
  logic [P-1:0]     mcand, mplier, man;
  logic [2*P-1:0]   prod;
  logic [CW-1:0]    count;
  logic signed [EW-1:0] expR;
  logic             guard, sticky;

  logic [EXP_W-1:0] eA, eB;
  logic [MAN_W-1:0] fA, fB;
  logic nanA, nanB, infA, infB, zeroA, zeroB, special, sgnAB;
  logic signed [EW-1:0] eSum;

  assign eA = aReg[W-2:MAN_W];
  assign eB = bReg[W-2:MAN_W];
  assign fA = aReg[MAN_W-1:0];
  assign fB = bReg[MAN_W-1:0];
  assign nanA  = (&eA) & (|fA);
  assign nanB  = (&eB) & (|fB);
  assign infA  = (&eA) & ~(|fA);
  assign infB  = (&eB) & ~(|fB);
  assign zeroA = ~(|eA);
  assign zeroB = ~(|eB);
  assign special = nanA | nanB | infA | infB | zeroA | zeroB;
  assign sgnAB = aReg[W-1] ^ bReg[W-1];
  assign eSum = $signed({2'b00, eA}) + $signed({2'b00, eB}) - BIAS;
  assign busy = (state != IDLE);

  logic [W-1:0] spRes;
  logic         spInv;

  always_comb begin
    spRes = {sgnAB, {(W-1){1'b0}}};
    spInv = 1'b0;
    if (nanA | nanB) begin
      spRes = QNAN;
    end else if ((infA | infB) & (zeroA | zeroB)) begin
      spRes = QNAN;
      spInv = 1'b1;
    end else if (infA | infB) begin
      spRes = {sgnAB, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic [P:0]   addV, hiSum, manR;
  logic         inc;
  logic signed [EW-1:0] eRnd;
  logic [W-1:0] rndRes;
  logic         rndOvf, rndUnf;

  assign addV  = mplier[0] ? {1'b0, mcand} : '0;
  assign hiSum = {1'b0, prod[2*P-1:P]} + addV;
  assign inc   = rnd & guard & (sticky | man[0]);
  assign manR  = {1'b0, man} + {{P{1'b0}}, inc};
  // Carry-out leaves the fraction bits at zero, i.e. mantissa 1.0.
  assign eRnd  = expR + $signed({{(EW-1){1'b0}}, manR[P]});

  always_comb begin
    rndRes = {sgn, eRnd[EXP_W-1:0], manR[MAN_W-1:0]};
    rndOvf = 1'b0;
    rndUnf = 1'b0;
    if (eRnd >= EMAX) begin
      rndRes = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rndOvf = 1'b1;
    end else if (eRnd <= 0) begin
      rndRes = {sgn, {(W-1){1'b0}}};
      rndUnf = 1'b1;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (startFP) nextState = LOAD_A;
      LOAD_A:  nextState = LOAD_B;
      LOAD_B:  nextState = CHECK;
      CHECK:   nextState = special ? IDLE : MULT;
      MULT:    if (count == CW'(1)) nextState = NORM;
      NORM:    nextState = ROUND;
      ROUND:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aReg   <= '0;
      bReg   <= '0;
      rnd    <= 1'b0;
      sgn    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      count  <= '0;
      expR   <= '0;
      man    <= '0;
      guard  <= 1'b0;
      sticky <= 1'b0;
      resBus <= '0;
      doneFP <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      inv    <= 1'b0;
    end else begin
      doneFP <= 1'b0;
      unique case (state)
        LOAD_A: aReg <= inBus;
        LOAD_B: begin
          bReg <= inBus;
          rnd  <= rndMode;
        end
        CHECK: begin
          sgn <= sgnAB;
          if (special) begin
            resBus <= spRes;
            inv    <= spInv;
            ovf    <= 1'b0;
            unf    <= 1'b0;
            doneFP <= 1'b1;
          end else begin
            mcand  <= {1'b1, fA};
            mplier <= {1'b1, fB};
            prod   <= '0;
            count  <= CW'(P);
            expR   <= eSum;
          end
        end
        MULT: begin
          prod   <= {hiSum, prod[P-1:1]};
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
        end
        NORM: begin
          if (prod[2*P-1]) begin
            man    <= prod[2*P-1:P];
            guard  <= prod[P-1];
            sticky <= |prod[P-2:0];
            expR   <= expR + EONE;
          end else begin
            man    <= prod[2*P-2:P-1];
            guard  <= prod[P-2];
            sticky <= |prod[P-3:0];
          end
        end
        ROUND: begin
          resBus <= rndRes;
          ovf    <= rndOvf;
          unf    <= rndUnf;
          inv    <= 1'b0;
          doneFP <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_mult_param.sv
// Directed checks of fp_mult_param at single and half precision.
// Expected results are hand-computed IEEE products.
module tb_fp_mult_param;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inBus;
  logic        rndMode;
  logic        start32, start16;
  logic [31:0] res32;
  logic [15:0] res16;
  logic done32, busy32, ovf32, unf32, inv32;
  logic done16, busy16, ovf16, unf16, inv16;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_mult_param u32 (
    .clk(clk), .rst(rst), .inBus(inBus), .startFP(start32),
    .rndMode(rndMode), .resBus(res32), .doneFP(done32),
    .busy(busy32), .ovf(ovf32), .unf(unf32), .inv(inv32)
  );

  fp_mult_param #(.EXP_W(5), .MAN_W(10)) u16 (
    .clk(clk), .rst(rst), .inBus(inBus[15:0]), .startFP(start16),
    .rndMode(rndMode), .resBus(res16), .doneFP(done16),
    .busy(busy16), .ovf(ovf16), .unf(unf16), .inv(inv16)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit          half;
    logic [31:0] a;
    logic [31:0] b;
    logic        rm;
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
  } vec_t;

  task automatic runOp(input bit half, input logic [31:0] a,
                       input logic [31:0] b, input logic rm,
                       input bit poke, output logic [31:0] res,
                       output logic [2:0] flg, output int lat);
    logic [31:0] prev;
    bit seen;
    prev = half ? {16'h0, res16} : res32;
    @(posedge clk); #1;
    if (half) start16 = 1'b1;
    else start32 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    start32 = 1'b0;
    inBus = a;
    @(posedge clk); #1;
    inBus = b;
    rndMode = rm;
    @(posedge clk); #1;
    inBus = '0;
    lat = -1;
    seen = 0;
    for (int k = 3; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      if (poke && k == 8) begin
        start32 = 1'b1;
        inBus = 32'h3F800000;
      end
      if (poke && k == 9) start32 = 1'b0;
      if (half ? done16 : done32) begin
        seen = 1;
        lat = k;
      end else if (poke) begin
        chk("holdRes", res32, prev);
      end
    end
    res = half ? {16'h0, res16} : res32;
    flg = half ? {ovf16, unf16, inv16} : {ovf32, unf32, inv32};
    if (seen) begin
      chk("busyAtDone", {31'b0, half ? busy16 : busy32}, 32'd0);
      @(posedge clk); #1;
      chk("doneFall", {31'b0, half ? done16 : done32}, 32'd0);
    end
  endtask

  vec_t vecs[$];
  logic [31:0] r;
  logic [2:0]  f;
  int          lat;
  bit          sawDone;

  initial begin
    vecs.push_back('{0, 32'h412B3333, 32'h40200000, 1, 32'h41D60000, 3'b000, 29});
    vecs.push_back('{0, 32'h412B3333, 32'h40200000, 0, 32'h41D5FFFF, 3'b000, 29});
    vecs.push_back('{0, 32'h3FC00000, 32'h3FC00000, 1, 32'h40100000, 3'b000, 29});
    vecs.push_back('{0, 32'h7F000000, 32'h40000000, 1, 32'h7F800000, 3'b100, 29});
    vecs.push_back('{0, 32'h00800000, 32'h3F000000, 1, 32'h00000000, 3'b010, 29});
    vecs.push_back('{0, 32'h7F800000, 32'h00000000, 1, 32'h7FC00000, 3'b001, 3});
    vecs.push_back('{0, 32'h7FC00001, 32'h3F800000, 1, 32'h7FC00000, 3'b000, 3});
    vecs.push_back('{0, 32'hFF800000, 32'h40000000, 1, 32'hFF800000, 3'b000, 3});
    vecs.push_back('{0, 32'h80000000, 32'h40400000, 1, 32'h80000000, 3'b000, 3});
    vecs.push_back('{1, 32'h00003C00, 32'h00004000, 1, 32'h00004000, 3'b000, 16});
    vecs.push_back('{1, 32'h00007BFF, 32'h00004000, 1, 32'h00007C00, 3'b100, 16});
    vecs.push_back('{0, 32'hBFC00000, 32'h40000000, 1, 32'hC0400000, 3'b000, 29});

    rst = 1'b1;
    inBus = '0;
    rndMode = 1'b0;
    start32 = 1'b0;
    start16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstRes", res32, 32'h0);
    chk("rstFlags", {29'b0, ovf32, unf32, inv32}, 32'h0);
    chk("rstDone", {30'b0, done32, done16}, 32'h0);
    chk("rstBusy", {30'b0, busy32, busy16}, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      runOp(vecs[i].half, vecs[i].a, vecs[i].b, vecs[i].rm, 0, r, f, lat);
      chk($sformatf("res%0d", i), r, vecs[i].res);
      chk($sformatf("flg%0d", i), {29'b0, f}, {29'b0, vecs[i].flg});
      chk($sformatf("lat%0d", i), lat, vecs[i].lat);
    end

    runOp(0, 32'h3FC00000, 32'h3FC00000, 1, 1, r, f, lat);
    chk("pokeRes", r, 32'h40100000);
    chk("pokeLat", lat, 32'd29);
    sawDone = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (done32 || busy32) sawDone = 1;
    end
    chk("pokeNoRestart", {31'b0, sawDone}, 32'd0);

    @(posedge clk); #1;
    start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    inBus = 32'h3FC00000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    repeat (7) @(posedge clk);
    #1;
    chk("busyMult", {31'b0, busy32}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midRstRes", res32, 32'h0);
    chk("midRstFlags", {29'b0, ovf32, unf32, inv32}, 32'h0);
    chk("midRstBusy", {31'b0, busy32}, 32'd0);
    chk("midRstDone", {31'b0, done32}, 32'd0);
    rst = 1'b0;
    sawDone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) sawDone = 1;
    end
    chk("midRstNoDone", {31'b0, sawDone}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fp_mult_param.md
# fp_mult_param

Parametrised sequential floating-point multiplier, the successor to the fixed 32-bit FP multiplier top. Operands arrive serially over one input bus after a start strobe. A shift-add mantissa datapath processes one multiplier bit per cycle. The block adds selectable rounding, IEEE special-value handling and status flags. It sits on the shared operand bus as a start/done coprocessor.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W, BIAS = 2^(EXP_W-1)-1
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- inBus  in  W  operand bus, carries A, then B on consecutive cycles
- startFP  in  1  start strobe, sampled only in IDLE
- rndMode  in  1  0 = truncate, 1 = round-to-nearest-even; captured with B
- resBus  out  W  result, held until the next result is written
- doneFP  out  1  one-cycle pulse, result valid
- busy  out  1  high in every state except IDLE
- ovf, unf, inv  out  1 each  overflow, underflow, invalid flags; written with resBus and held with it

## Operation
- States: IDLE → LOAD_A → LOAD_B → CHECK → MULT → NORM → ROUND → IDLE.
- IDLE: if startFP=1 at an edge, go to LOAD_A. startFP is ignored in every other state.
- LOAD_A edge: A ← inBus. LOAD_B edge: B ← inBus, rnd ← rndMode.
- CHECK edge: decode operands. Exponent 0 means zero; denormals are flushed. Sign = sA^sB.
- Special results skip MULT/NORM/ROUND. CHECK writes resBus and flags, pulses doneFP and returns to IDLE:
  - either operand NaN (exp all ones, frac≠0) → canonical qNaN: sign 0, exp all ones, frac MSB 1, rest 0. inv=0.
  - inf×0 → qNaN, inv=1.
  - inf×finite nonzero, or inf×inf → signed inf.
  - zero×finite → signed zero, flags 0.
- Otherwise CHECK loads the hidden-1 mantissas (MAN_W+1 bits), a 2(MAN_W+1)-bit product register cleared to 0, and count = MAN_W+1. It also loads exponent e = eA+eB−BIAS, kept in EXP_W+2 signed bits.
- MULT: each edge adds or skips the multiplicand according to the multiplier LSB, shifts, and decrements count. When count reaches 0, go to NORM.
- NORM: if product MSB = 1, take the mantissa from the top MAN_W+1 bits and do e+1. Otherwise take the next MAN_W+1 bits. Guard = next bit; sticky = OR of the remaining bits.
- ROUND: for RNE, increment if guard & (sticky | mantissa LSB). Truncate never increments. A rounding carry-out gives mantissa = 1.0 and e+1.
  - Range check is done after rounding.
  - e ≥ 2^EXP_W−1 → signed inf, ovf=1.
  - e ≤ 0 → signed zero, unf=1.
  - Otherwise the normal result.
  - Writes resBus and flags, pulses doneFP, returns to IDLE.
- On reset:
  - state = IDLE.
  - resBus, ovf, unf, inv, doneFP and busy = 0.
  - Internal registers are cleared.
  - This applies mid-operation as well; the pending result is discarded and no doneFP is produced.

## Timing
- Edge 0 samples startFP=1. Edge 1 captures A, edge 2 captures B, edge 3 is CHECK.
- MULT occupies edges 4 … 4+MAN_W. NORM is edge 5+MAN_W, ROUND is edge 6+MAN_W.
- Normal path: doneFP is high for the cycle after edge 6+MAN_W, i.e. after edge 29 for the default widths. busy falls at the same edge.
- Special path: doneFP is high for the cycle after edge 3.
- A new startFP can be sampled on the edge that ends the doneFP cycle.
- resBus and the flags change only on the edge that raises doneFP.
- startFP held high for multiple cycles starts exactly one operation. A fresh start requires IDLE.

## Test plan
- Default widths, RNE: A=0x412B3333 (10.7), B=0x40200000 (2.5) → resBus=0x41D60000, doneFP after edge 29, flags 0. Same operands with truncate → 0x41D5FFFF.
- Sign and normalize: 0xBFC00000 × 0x40000000 → 0xC0400000 (−3.0). Also 0x3FC00000 × 0x3FC00000 → 0x40100000 (2.25, exercises the product-MSB shift).
- Overflow and underflow: 0x7F000000 × 0x40000000 → 0x7F800000 with ovf=1. 0x00800000 × 0x3F000000 → 0x00000000 with unf=1.
- Specials: 0x7F800000 × 0x00000000 → 0x7FC00000, inv=1, doneFP after edge 3. 0x7FC00001 × 1.0 → 0x7FC00000, inv=0. 0xFF800000 × 0x40000000 → 0xFF800000.
- Control: rst=1 during MULT → all outputs 0 on the next edge, no doneFP. startFP pulsed while busy is ignored, and resBus is unchanged until the original op's doneFP.
- Parametrisation: EXP_W=5, MAN_W=10 (half precision), 0x3C00 × 0x4000 → 0x4000, doneFP after edge 16. 0x7BFF × 0x4000 → 0x7C00 with ovf=1.
